// File: rtl/stream_arb_mux_pkg.sv
// stream_arb_mux shared definitions: arbitration modes and
// a one-hot to index helper used by the arbiter and the top.
package stream_mux_pkg;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_PRIO   = 2'b01;
    localparam logic [1:0] MODE_RR     = 2'b10;

    // Widest supported channel count; grant vectors are
    // zero-extended to this width before index conversion.
    localparam int MAXN = 16;

    // Index of the set bit in a one-hot vector (0 if none set).
    function automatic int unsigned oh2idx(input logic [MAXN-1:0] oh);
        int unsigned r;
        r = 0;
        for (int i = 0; i < MAXN; i++) begin
            if (oh[i]) begin
                r = unsigned'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_arb_mux_if.sv
// Handshake bundle of stream_arb_mux: N input channels and
// one registered output channel, each with valid/ready.
interface stream_arb_mux_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic [SW-1:0]      out_sel;
    logic               out_ready;

    // Producer/consumer side
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );

    // Multiplexer side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );

endinterface

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Fixed-priority / round-robin grant logic with the
// round-robin pointer register.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         prio_mode,
    input  logic         upd,
    output logic [N-1:0] grant
);

    logic [SW-1:0]   ptr;
    logic [SW-1:0]   ptr_nxt;
    logic [MAXN-1:0] gext;
    int unsigned     gi;

    // First requester at or after the search base, wrapping;
    // fixed priority simply searches from channel 0.
    always_comb begin : search
        int   base;
        int   k;
        logic found;
        grant = '0;
        found = 1'b0;
        k     = 0;
        base  = prio_mode ? 0 : int'(ptr);
        for (int c = 0; c < N; c++) begin
            k = (base + c) % N;
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Pointer moves to the slot just past the winner.
    always_comb begin
        gext        = '0;
        gext[N-1:0] = grant;
        gi          = oh2idx(gext);
        if (gi >= unsigned'(N - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = SW'(gi + 1);
        end
    end

    // Pointer advances only on an accepted round-robin transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// Registered N-way stream merger with static, fixed-priority
// and round-robin arbitration and full-throughput handshakes.
module stream_arb_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [SW-1:0] sel,
    stream_arb_mux_if.slave bus
);

    logic            load;
    logic            xfer;
    logic            prio;
    logic            rr_upd;
    logic [N-1:0]    arb_grant;
    logic [N-1:0]    st_grant;
    logic [N-1:0]    grant;
    logic [MAXN-1:0] gext;
    int unsigned     gidx;

    // Output register can accept when empty or draining.
    assign load = !bus.out_valid || bus.out_ready;

    // Static grant; an out-of-range sel matches no channel.
    always_comb begin
        st_grant = '0;
        for (int i = 0; i < N; i++) begin
            st_grant[i] = (int'(sel) == i) && bus.in_valid[i];
        end
    end

    // Reserved mode falls back to static selection.
    always_comb begin
        grant = st_grant;
        unique case (mode)
            MODE_PRIO, MODE_RR: grant = arb_grant;
            default:            grant = st_grant;
        endcase
    end

    assign bus.in_ready = (rst || !load) ? '0 : grant;
    assign xfer         = |bus.in_ready;
    assign prio         = (mode == MODE_PRIO);
    assign rr_upd       = xfer && (mode == MODE_RR);

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.in_valid),
        .prio_mode (prio),
        .upd       (rr_upd),
        .grant     (arb_grant)
    );

    // Winner index for the data mux and out_sel.
    always_comb begin
        gext        = '0;
        gext[N-1:0] = grant;
        gidx        = oh2idx(gext);
    end

    // Output stage: load granted word, or go empty if none.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
        end else if (load) begin
            if (|grant) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.in_data[int'(gidx)*WIDTH +: WIDTH];
                bus.out_sel   <= SW'(gidx);
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux with a reference grant
// model feeding a scoreboard of expected output words.
module tb_stream_arb_mux;
    import stream_mux_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [1:0] s;
        logic [7:0] d;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] sel;
    logic [1:0] mode8;
    logic [2:0] sel8;

    int   nt;
    int   nf;
    logic m_ov;
    int   m_ptr;
    exp_t sb[$];

    stream_arb_mux_if #(.WIDTH(W), .N(N)) bus ();
    stream_arb_mux_if #(.WIDTH(W), .N(8)) bus8 ();

    stream_arb_mux #(.WIDTH(W), .N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .sel  (sel),
        .bus  (bus)
    );

    stream_arb_mux #(.WIDTH(W), .N(8)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .mode (mode8),
        .sel  (sel8),
        .bus  (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        nt++;
        assert (obs === exp) else begin
            nf++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_grant(
        input logic [1:0] md, input logic [1:0] s,
        input logic [3:0] v, input int p);
        int start;
        if (md == MODE_PRIO || md == MODE_RR) begin
            start = (md == MODE_PRIO) ? 0 : p;
            for (int c = 0; c < 4; c++) begin
                if (v[(start + c) % 4]) begin
                    return 4'(1 << ((start + c) % 4));
                end
            end
            return 4'b0000;
        end
        return v[s] ? 4'(1 << s) : 4'b0000;
    endfunction

    // One clock: check handshake and output, then advance.
    task automatic step();
        logic       ld;
        logic [3:0] er;
        int         idx;
        exp_t       e;
        #1;
        ld = !m_ov || bus.out_ready;
        er = ld ? model_grant(mode, sel, bus.in_valid, m_ptr) : 4'b0;
        check("in_ready", 64'(bus.in_ready), 64'(er));
        if (m_ov) begin
            check("out_valid", 64'(bus.out_valid), 64'd1);
            if (sb.size() == 0) begin
                nt++;
                nf++;
                $error("FAIL scoreboard_empty observed=1 expected=0");
            end else begin
                check("out_data", 64'(bus.out_data), 64'(sb[0].d));
                check("out_sel", 64'(bus.out_sel), 64'(sb[0].s));
                if (bus.out_ready) begin
                    void'(sb.pop_front());
                end
            end
        end else begin
            check("out_valid", 64'(bus.out_valid), 64'd0);
        end
        if (er != 4'b0) begin
            idx = 0;
            for (int i = 0; i < 4; i++) begin
                if (er[i]) idx = i;
            end
            e.s = 2'(idx);
            e.d = bus.in_data[idx*W +: W];
            sb.push_back(e);
            m_ov = 1'b1;
            if (mode == MODE_RR) m_ptr = (idx + 1) % 4;
        end else if (ld) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_sel", 64'(bus.out_sel), 64'd0);
        rst   = 1'b0;
        m_ov  = 1'b0;
        m_ptr = 0;
        sb.delete();
    endtask

    initial begin
        nt = 0;
        nf = 0;
        m_ov = 1'b0;
        m_ptr = 0;
        rst = 1'b1;
        mode = MODE_RR;
        sel = 2'd0;
        bus.in_valid = 4'hF;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        mode8 = MODE_STATIC;
        sel8 = 3'd0;
        bus8.in_valid = '0;
        bus8.in_data = '0;
        bus8.out_ready = 1'b1;

        do_reset(2);

        // static select of channel 2
        mode = MODE_STATIC;
        sel = 2'd2;
        bus.in_data = 32'h44A5_2211;
        step();
        step();
        bus.in_valid = 4'h0;
        step();
        step();
        check("hold_data", 64'(bus.out_data), 64'hA5);
        check("hold_sel", 64'(bus.out_sel), 64'd2);

        // fixed priority: channel 1 always beats 3
        mode = MODE_PRIO;
        bus.in_valid = 4'b1010;
        repeat (4) begin
            bus.in_data = $urandom();
            step();
        end

        // round robin, all valid then sparse
        mode = MODE_RR;
        bus.in_valid = 4'hF;
        repeat (5) begin
            bus.in_data = $urandom();
            step();
        end
        bus.in_valid = 4'b1001;
        repeat (4) begin
            bus.in_data = $urandom();
            step();
        end

        // backpressure with a held word
        bus.in_valid = 4'hF;
        step();
        bus.out_ready = 1'b0;
        repeat (3) begin
            bus.in_data = $urandom();
            step();
        end
        bus.out_ready = 1'b1;
        step();
        step();

        // reset while a word is stuck
        bus.out_ready = 1'b0;
        bus.in_data = $urandom();
        step();
        do_reset(1);
        bus.out_ready = 1'b1;
        bus.in_data = 32'hDDCC_BBAA;
        step();
        check("post_rst_sel", 64'(bus.out_sel), 64'd0);
        check("post_rst_data", 64'(bus.out_data), 64'hAA);
        step();

        // 8-channel build: sel past the valid channels
        bus.in_valid = 4'h0;
        bus8.in_data = 64'h8877_6655_445A_2211;
        bus8.in_valid = 8'h0F;
        sel8 = 3'd2;
        #1;
        check("n8_in_ready", 64'(bus8.in_ready), 64'h04);
        step();
        check("n8_out_valid", 64'(bus8.out_valid), 64'd1);
        check("n8_out_data", 64'(bus8.out_data), 64'h5A);
        check("n8_out_sel", 64'(bus8.out_sel), 64'd2);
        sel8 = 3'd5;
        #1;
        check("n8_no_grant", 64'(bus8.in_ready), 64'h00);
        step();
        check("n8_drop", 64'(bus8.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
